// File: rtl/bram_mac_engine.sv
// Streams packed int16 weight/pixel words from BRAM port B, accumulates the dot
// product, saturates it to int32 and writes it back. Build option: MAC_RELU_EN.
//
// state   | meaning
// IDLE    | waiting for start; done pulses here right after WRITE
// ISSUE   | one operand read per cycle, len cycles
// DRAIN   | reads finished, waiting for the read/multiply pipeline to empty
// WRITE   | saturated sum written to res_addr
module bram_mac_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 42,
  parameter int RD_LAT = 1
) (
  input  logic              s_axi_aclk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] BRAM_PORTB_addr,
  output logic [DATA_W-1:0] BRAM_PORTB_din,
  input  logic [DATA_W-1:0] BRAM_PORTB_dout,
  output logic              BRAM_PORTB_en,
  output logic              BRAM_PORTB_we
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   res_q, res_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic [RD_LAT-1:0]   sr_q, sr_d;
  logic [31:0]         prod_q, prod_d;
  logic                pv_q, pv_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [31:0]         result_q, result_d;
  logic                done_q, done_d;

  logic                accept;
  logic [31:0]         w_ext, p_ext;
  logic [31:0]         sat_val, out_val;

  assign accept = (state_q == S_IDLE) && start && !done_q;

  // Read pipeline: sr_q marks which issued reads have data arriving; the tap
  // at RD_LAT-1 lines up with valid dout.
  always_comb begin
    sr_d    = '0;
    sr_d[0] = en_q & ~we_q;
    for (int i = 1; i < RD_LAT; i++) sr_d[i] = sr_q[i-1];
    w_ext  = {{16{BRAM_PORTB_dout[31]}}, BRAM_PORTB_dout[31:16]};
    p_ext  = {{16{BRAM_PORTB_dout[15]}}, BRAM_PORTB_dout[15:0]};
    pv_d   = sr_q[RD_LAT-1];
    prod_d = prod_q;
    if (sr_q[RD_LAT-1]) prod_d = w_ext * p_ext;
  end

  always_comb begin
    acc_d = acc_q;
    if (accept)    acc_d = '0;
    else if (pv_q) acc_d = acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};
  end

  // Saturation looks at the accumulator value being committed this edge, so
  // the registered write data already contains the final product.
  always_comb begin
    sat_val = acc_d[31:0];
    if (!(&acc_d[ACC_W-1:31]) && (|acc_d[ACC_W-1:31]))
      sat_val = acc_d[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    out_val = sat_val;
`ifdef MAC_RELU_EN
    if (sat_val[31]) out_val = '0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    addr_d   = addr_q;
    din_d    = din_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    result_d = result_q;
    done_d   = (state_q == S_WRITE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          res_d = res_addr;
          if (len != '0) begin
            state_d = S_ISSUE;
            en_d    = 1'b1;
            addr_d  = base_addr;
            cnt_d   = len - ADDR_W'(1);
          end else begin
            state_d = S_WRITE;
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = res_addr;
            din_d   = DATA_W'(out_val);
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q != '0) begin
          en_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sr_q == '0) begin
          state_d = S_WRITE;
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = res_q;
          din_d   = DATA_W'(out_val);
        end
      end
      S_WRITE: begin
        state_d  = S_IDLE;
        result_d = din_q[31:0];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      sr_q     <= '0;
      prod_q   <= '0;
      pv_q     <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      en_q     <= en_d;
      we_q     <= we_d;
      sr_q     <= sr_d;
      prod_q   <= prod_d;
      pv_q     <= pv_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign result          = result_q;
  assign BRAM_PORTB_addr = addr_q;
  assign BRAM_PORTB_din  = din_q;
  assign BRAM_PORTB_en   = en_q;
  assign BRAM_PORTB_we   = we_q;

endmodule

// File: tb/tb_bram_mac_engine.sv
// Directed bench for bram_mac_engine: two instances (read latency 1 and 2)
// each backed by a behavioural BRAM model that the bench preloads.
module tb_bram_mac_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        st1, st2;
  logic [9:0]  base, len, res;
  logic        busy1, done1, en1, we1, busy2, done2, en2, we2;
  logic [31:0] result1, result2, din1, din2, dout1, dout2;
  logic [9:0]  addr1, addr2;

  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  logic [31:0] rd1, rd2a, rd2b;
  logic        ld_en;
  logic [9:0]  ld_a;
  logic [31:0] ld_d;

  logic        sel;
  logic        obs_en, obs_we, obs_busy, obs_done;
  logic [9:0]  obs_addr;
  logic [31:0] obs_din;

  int n_vec = 0;
  int n_err = 0;

  int r_done_cyc, r_n_done, r_wr_cyc, r_n_wr, r_busy_first, r_busy_last, r_n_busy;
  logic [31:0] r_wr_dat;
  logic [2:0]  r_post_rst;
  int iss_q[$];

`ifdef MAC_RELU_EN
  localparam logic [31:0] EXP_BASIC = 32'h0000_0000;
  localparam logic [31:0] EXP_NEG   = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_BASIC = 32'hFFFF_FFF9;
  localparam logic [31:0] EXP_NEG   = 32'h8000_0000;
`endif
  localparam logic [31:0] EXP_WRAP = 32'h0000_3C49;
  localparam logic [31:0] EXP_POS  = 32'h7FFF_FFFF;

  always #5 clk = ~clk;

  bram_mac_engine #(.RD_LAT(1)) u_dut1 (
    .s_axi_aclk(clk), .rst(rst), .start(st1), .base_addr(base), .len(len),
    .res_addr(res), .busy(busy1), .done(done1), .result(result1),
    .BRAM_PORTB_addr(addr1), .BRAM_PORTB_din(din1), .BRAM_PORTB_dout(dout1),
    .BRAM_PORTB_en(en1), .BRAM_PORTB_we(we1));

  bram_mac_engine #(.RD_LAT(2)) u_dut2 (
    .s_axi_aclk(clk), .rst(rst), .start(st2), .base_addr(base), .len(len),
    .res_addr(res), .busy(busy2), .done(done2), .result(result2),
    .BRAM_PORTB_addr(addr2), .BRAM_PORTB_din(din2), .BRAM_PORTB_dout(dout2),
    .BRAM_PORTB_en(en2), .BRAM_PORTB_we(we2));

  always @(posedge clk) begin
    if (ld_en) begin
      mem1[ld_a] <= ld_d;
      mem2[ld_a] <= ld_d;
    end else begin
      if (en1 && we1) mem1[addr1] <= din1;
      if (en2 && we2) mem2[addr2] <= din2;
    end
    if (en1) rd1 <= mem1[addr1];
    if (en2) rd2a <= mem2[addr2];
    rd2b <= rd2a;
  end
  assign dout1 = rd1;
  assign dout2 = rd2b;

  always_comb begin
    obs_en   = sel ? en2   : en1;
    obs_we   = sel ? we2   : we1;
    obs_busy = sel ? busy2 : busy1;
    obs_done = sel ? done2 : done1;
    obs_addr = sel ? addr2 : addr1;
    obs_din  = sel ? din2  : din1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ld(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Cycle 0 is the start cycle; outputs are sampled 1 time unit after each edge.
  task automatic run_op(input bit s, input logic [9:0] b, input logic [9:0] l,
                        input logic [9:0] r, input int poke_cyc,
                        input logic [9:0] poke_base, input int rst_cyc,
                        input int max_cyc);
    int t;
    sel = s; base = b; len = l; res = r;
    r_done_cyc = -1; r_n_done = 0; r_wr_cyc = -1; r_n_wr = 0; r_wr_dat = '0;
    r_busy_first = -1; r_busy_last = -1; r_n_busy = 0; r_post_rst = 3'b111;
    iss_q.delete();
    st1 = !s;
    st2 = s;
    t = 0;
    while (t < max_cyc) begin
      @(posedge clk); #1;
      t++;
      if (obs_en && !obs_we) iss_q.push_back(int'(obs_addr));
      if (obs_en && obs_we) begin
        r_n_wr++;
        r_wr_cyc = t;
        r_wr_dat = obs_din;
      end
      if (obs_done) begin
        r_n_done++;
        if (r_done_cyc < 0) r_done_cyc = t;
      end
      if (obs_busy) begin
        r_n_busy++;
        if (r_busy_first < 0) r_busy_first = t;
        r_busy_last = t;
      end
      if (t == rst_cyc + 1) r_post_rst = {obs_en, obs_we, obs_busy};
      st1  = !s && (t == poke_cyc);
      st2  = s && (t == poke_cyc);
      base = (t == poke_cyc) ? poke_base : b;
      rst  = (t == rst_cyc);
    end
    st1 = 1'b0;
    st2 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic load_basic();
    ld(10'd16, {16'sd2,  16'sd3});
    ld(10'd17, {-16'sd4, 16'sd5});
    ld(10'd18, {16'sd7,  16'sd1});
    ld(10'd19, {16'sd0,  16'sd100});
  endtask

  initial begin
    int exp_iss[4];
    rst = 1'b1; st1 = 1'b0; st2 = 1'b0; sel = 1'b0;
    base = '0; len = '0; res = '0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, busy1}, 32'd0);
    chk("rst_done",   {31'd0, done1}, 32'd0);
    chk("rst_en_we",  {30'd0, en1, we1}, 32'd0);
    chk("rst_addr",   {22'd0, addr1}, 32'd0);
    chk("rst_din",    din1, 32'd0);
    chk("rst_result", result1, 32'd0);
    chk("rst_dut2",   {29'd0, busy2, en2, we2}, 32'd0);
    rst = 1'b0;

    load_basic();
    ld(10'd100, 32'hDEAD_BEEF);
    ld(10'd0, {16'sd1, 16'sd1000});

    // basic dot product
    run_op(1'b0, 10'd16, 10'd4, 10'd100, -1, 10'd0, -10, 14);
    chk("basic_wr_dat",   r_wr_dat, EXP_BASIC);
    chk("basic_wr_cyc",   r_wr_cyc, 32'd7);
    chk("basic_done_cyc", r_done_cyc, 32'd8);
    chk("basic_n_done",   r_n_done, 32'd1);
    chk("basic_busy_1st", r_busy_first, 32'd1);
    chk("basic_busy_end", r_busy_last, 32'd7);
    chk("basic_n_busy",   r_n_busy, 32'd7);
    chk("basic_mem",      mem1[100], EXP_BASIC);
    chk("basic_result",   result1, EXP_BASIC);
    chk("basic_n_iss",    iss_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < iss_q.size(); i++)
      chk($sformatf("basic_iss%0d", i), iss_q[i], 32'(16 + i));

    // start while busy (cycle 3) and in the done cycle (cycle 8)
    run_op(1'b0, 10'd16, 10'd4, 10'd100, 3, 10'd0, -10, 16);
    chk("busy_start_n_done", r_n_done, 32'd1);
    chk("busy_start_n_iss",  iss_q.size(), 32'd4);
    chk("busy_start_wr",     r_wr_dat, EXP_BASIC);
    run_op(1'b0, 10'd16, 10'd4, 10'd100, 8, 10'd0, -10, 20);
    chk("done_start_n_done", r_n_done, 32'd1);
    chk("done_start_n_busy", r_n_busy, 32'd7);

    // len = 0
    ld(10'd200, 32'h1234_5678);
    run_op(1'b0, 10'd5, 10'd0, 10'd200, -1, 10'd0, -10, 6);
    chk("len0_wr_cyc",   r_wr_cyc, 32'd1);
    chk("len0_done_cyc", r_done_cyc, 32'd2);
    chk("len0_wr_dat",   r_wr_dat, 32'd0);
    chk("len0_mem",      mem1[200], 32'd0);
    chk("len0_n_iss",    iss_q.size(), 32'd0);
    chk("len0_n_busy",   r_n_busy, 32'd1);

    // address wrap
    ld(10'd1022, {16'sd100, 16'sd200});
    ld(10'd1023, {-16'sd300, 16'sd7});
    ld(10'd0,    {-16'sd1, -16'sd1});
    ld(10'd1,    {16'sd1234, -16'sd2});
    run_op(1'b0, 10'd1022, 10'd4, 10'd300, -1, 10'd0, -10, 12);
    exp_iss = '{1022, 1023, 0, 1};
    chk("wrap_n_iss", iss_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < iss_q.size(); i++)
      chk($sformatf("wrap_iss%0d", i), iss_q[i], exp_iss[i]);
    chk("wrap_mem",      mem1[300], EXP_WRAP);
    chk("wrap_done_cyc", r_done_cyc, 32'd8);

    // reset in cycle 3 of ISSUE, then a fresh operation
    for (int i = 0; i < 8; i++) ld(10'(500 + i), 32'h0003_0005);
    ld(10'd400, 32'hCAFE_F00D);
    run_op(1'b0, 10'd500, 10'd8, 10'd400, -1, 10'd0, 3, 16);
    chk("rstmid_post",      {29'd0, r_post_rst}, 32'd0);
    chk("rstmid_n_done",    r_n_done, 32'd0);
    chk("rstmid_n_wr",      r_n_wr, 32'd0);
    chk("rstmid_busy_end",  r_busy_last, 32'd3);
    chk("rstmid_mem",       mem1[400], 32'hCAFE_F00D);
    run_op(1'b0, 10'd16, 10'd4, 10'd400, -1, 10'd0, -10, 14);
    chk("rstmid_fresh_mem",  mem1[400], EXP_BASIC);
    chk("rstmid_fresh_done", r_done_cyc, 32'd8);

    // positive saturation over 1023 words
    for (int i = 0; i < 1023; i++) ld(10'(i), 32'h8000_8000);
    run_op(1'b0, 10'd0, 10'd1023, 10'd1023, -1, 10'd0, -10, 1032);
    chk("satpos_wr_dat",   r_wr_dat, EXP_POS);
    chk("satpos_mem",      mem1[1023], EXP_POS);
    chk("satpos_done_cyc", r_done_cyc, 32'd1027);
    chk("satpos_result",   result1, EXP_POS);

    // negative saturation
    for (int i = 0; i < 3; i++) ld(10'(i), 32'h8000_7FFF);
    run_op(1'b0, 10'd0, 10'd3, 10'd1023, -1, 10'd0, -10, 10);
    chk("satneg_wr_dat", r_wr_dat, EXP_NEG);
    chk("satneg_mem",    mem1[1023], EXP_NEG);
    chk("satneg_done",   r_done_cyc, 32'd7);

    // read latency 2
    load_basic();
    ld(10'd100, 32'hDEAD_BEEF);
    run_op(1'b1, 10'd16, 10'd4, 10'd100, -1, 10'd0, -10, 14);
    chk("lat2_wr_dat",   r_wr_dat, EXP_BASIC);
    chk("lat2_wr_cyc",   r_wr_cyc, 32'd8);
    chk("lat2_done_cyc", r_done_cyc, 32'd9);
    chk("lat2_n_done",   r_n_done, 32'd1);
    chk("lat2_mem",      mem2[100], EXP_BASIC);
    chk("lat2_result",   result2, EXP_BASIC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
